// File: rtl/poly_square_synth.sv
// poly_square_synth: multi-voice square-wave synthesizer for the clk_calc domain.
// Each voice has a half-period oscillator and a linear attack/release envelope.
// The voices are mixed into one signed sample, which is registered on every sample_tick.
// The mix headroom is set so that the sum of all voices at full level always fits OUT_W.
module poly_square_synth #(
   parameter int VOICES       = 4,
   parameter int PERIOD_W     = 23,
   parameter int OUT_W        = 24,
   parameter int AMP_W        = 8,
   parameter int ATTACK_STEP  = 16,
   parameter int RELEASE_STEP = 8
) (
   input  logic              clk_calc,
   input  logic              rst,
   input  logic              cmd_wren,
   input  logic [31:0]       cmd_data,
   output logic              cmd_full,
   output logic              cmd_err,
   input  logic              sample_tick,
   output logic [OUT_W-1:0]  audio,
   output logic              audio_valid,
   output logic [VOICES-1:0] busy
);

   // Left shift that places AMP_W-bit levels so VOICES of them cannot overflow OUT_W.
   localparam int SHIFT = OUT_W - 1 - AMP_W - $clog2(VOICES);

   localparam logic [AMP_W-1:0] LEVEL_MAX   = '1;
   localparam logic [AMP_W:0]   ATTACK_INC  = (AMP_W+1)'(ATTACK_STEP);
   localparam logic [AMP_W:0]   RELEASE_DEC = (AMP_W+1)'(RELEASE_STEP);

   typedef enum logic [1:0] {
      IDLE,
      ATTACK,
      SUSTAIN,
      RELEASE
   } voice_state_t;

   // Per-voice registered state (_q) and its next value (_d).
   voice_state_t        state_q  [VOICES];
   voice_state_t        state_d  [VOICES];
   logic [PERIOD_W-1:0] period_q [VOICES];
   logic [PERIOD_W-1:0] period_d [VOICES];
   logic [PERIOD_W-1:0] cnt_q    [VOICES];
   logic [PERIOD_W-1:0] cnt_d    [VOICES];
   logic                pol_q    [VOICES];
   logic                pol_d    [VOICES];
   logic [AMP_W-1:0]    level_q  [VOICES];
   logic [AMP_W-1:0]    level_d  [VOICES];

   // Command decode.
   logic [3:0]          cmd_idx;
   logic [PERIOD_W-1:0] cmd_period;
   logic                cmd_accept;
   logic                cmd_bad;
   logic                unused_cmd_bits;

   assign cmd_idx         = cmd_data[31:28];
   assign cmd_period      = cmd_data[PERIOD_W-1:0];
   assign cmd_accept      = cmd_wren & ~cmd_full;
   assign cmd_bad         = cmd_accept && ({1'b0, cmd_idx} >= 5'(VOICES));
   assign unused_cmd_bits = ^cmd_data[27:PERIOD_W];

   logic [AMP_W:0]   level_up;
   logic [OUT_W-1:0] mix;
   logic [OUT_W-1:0] term;

   // Next-state logic for every voice: oscillator, then envelope, then the command overrides both.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
      level_up = '0;
      for (int v = 0; v < VOICES; v++) begin
         state_d[v]  = state_q[v];
         period_d[v] = period_q[v];
         cnt_d[v]    = cnt_q[v];
         pol_d[v]    = pol_q[v];
         level_d[v]  = level_q[v];

         // Oscillator: runs in every state except IDLE, where cnt and pol hold their values.
         if (state_q[v] != IDLE) begin
            if (cnt_q[v] == period_q[v] - PERIOD_W'(1)) begin
               cnt_d[v] = '0;
               pol_d[v] = ~pol_q[v];
            end else begin
               cnt_d[v] = cnt_q[v] + PERIOD_W'(1);
            end
         end

         // Envelope: one linear step per sample tick.
         if (sample_tick) begin
            case (state_q[v])
               ATTACK: begin
                  level_up = {1'b0, level_q[v]} + ATTACK_INC;
                  if (level_up >= {1'b0, LEVEL_MAX}) begin
                     level_d[v] = LEVEL_MAX;
                     state_d[v] = SUSTAIN;
                  end else begin
                     level_d[v] = level_up[AMP_W-1:0];
                  end
               end
               RELEASE: begin
                  if ({1'b0, level_q[v]} <= RELEASE_DEC) begin
                     level_d[v] = '0;
                     state_d[v] = IDLE;
                  end else begin
                     level_d[v] = level_q[v] - RELEASE_DEC[AMP_W-1:0];
                  end
               end
               default: ;
            endcase
         end

         // A command to this voice wins over a coincident envelope step.
         if (cmd_accept && !cmd_bad && (cmd_idx == 4'(v))) begin
            level_d[v] = level_q[v];
            if (cmd_period != '0) begin
               // Note on: restart the half-period count, keep pol and level (legato).
               period_d[v] = cmd_period;
               cnt_d[v]    = '0;
               pol_d[v]    = pol_q[v];
               state_d[v]  = ATTACK;
            end else if (state_q[v] == ATTACK || state_q[v] == SUSTAIN) begin
               // Note off: the period is kept so the tone sounds through the release.
               state_d[v] = RELEASE;
            end else begin
               state_d[v] = state_q[v];
            end
         end
      end
   end

   // Per-voice state registers.
   always_ff @(posedge clk_calc) begin
      if (rst) begin
         // NOTE: all per-voice registers are reset because their values are visible through audio and busy.
         for (int v = 0; v < VOICES; v++) begin
            state_q[v]  <= IDLE;
            period_q[v] <= '0;
            cnt_q[v]    <= '0;
            pol_q[v]    <= 1'b0;
            level_q[v]  <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments, so every register samples values from before this edge.
         for (int v = 0; v < VOICES; v++) begin
            state_q[v]  <= state_d[v];
            period_q[v] <= period_d[v];
            cnt_q[v]    <= cnt_d[v];
            pol_q[v]    <= pol_d[v];
            level_q[v]  <= level_d[v];
         end
      end
   end

   // Mixer: signed sum of +/-(level << SHIFT) over all voices, using current register values.
   always_comb begin
      mix  = '0;
      term = '0;
      for (int v = 0; v < VOICES; v++) begin
         term = OUT_W'(level_q[v]) << SHIFT;
         mix  = pol_q[v] ? (mix + term) : (mix - term);
      end
   end

   // Busy flags: a voice is busy whenever it is not IDLE.
   always_comb begin
      busy = '0;
      for (int v = 0; v < VOICES; v++) begin
         busy[v] = (state_q[v] != IDLE);
      end
   end

   // Output registers: back-pressure flag, error pulse and the sample register.
   always_ff @(posedge clk_calc) begin
      if (rst) begin
         cmd_full    <= 1'b1;
         cmd_err     <= 1'b0;
         audio       <= '0;
         audio_valid <= 1'b0;
      end else begin
         cmd_full    <= 1'b0;
         cmd_err     <= cmd_bad;
         audio_valid <= sample_tick;
         if (sample_tick) begin
            audio <= mix;
         end
      end
   end

endmodule

// File: tb/tb_poly_square_synth.sv
// Directed testbench for poly_square_synth with the default parameters (4 voices, 24-bit output).
// Every expected value is a hand-derived constant or a simple closed-form expression.
module tb_poly_square_synth;

   localparam int VOICES = 4;
   localparam int OUT_W  = 24;

   logic              clk_calc = 1'b0;
   logic              rst;
   logic              cmd_wren;
   logic [31:0]       cmd_data;
   logic              cmd_full;
   logic              cmd_err;
   logic              sample_tick;
   logic [OUT_W-1:0]  audio;
   logic              audio_valid;
   logic [VOICES-1:0] busy;

   int checks = 0;
   int errors = 0;

   always #5 clk_calc = ~clk_calc;

   poly_square_synth #(
      .VOICES      (VOICES),
      .PERIOD_W    (23),
      .OUT_W       (OUT_W),
      .AMP_W       (8),
      .ATTACK_STEP (16),
      .RELEASE_STEP(8)
   ) dut (
      .clk_calc   (clk_calc),
      .rst        (rst),
      .cmd_wren   (cmd_wren),
      .cmd_data   (cmd_data),
      .cmd_full   (cmd_full),
      .cmd_err    (cmd_err),
      .sample_tick(sample_tick),
      .audio      (audio),
      .audio_valid(audio_valid),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic signed [31:0] observed,
                        input logic signed [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One clock edge; outputs are then read 1 time unit after it.
   task automatic step();
      @(posedge clk_calc);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic [31:0] d, input logic tick);
      cmd_wren    = 1'b1;
      cmd_data    = d;
      sample_tick = tick;
      step();
      cmd_wren    = 1'b0;
      sample_tick = 1'b0;
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
   endtask

   // Watchdog: the sequence is fixed-length, so this only fires if simulation stalls.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lvl;
      int sgn_sustain [10];
      sgn_sustain = '{1, 1, 1, 1, -1, -1, -1, -1, -1, 1};

      // 1. Reset held 3 cycles with command and tick active.
      rst         = 1'b1;
      cmd_wren    = 1'b1;
      cmd_data    = 32'h0000_0005;
      sample_tick = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_audio", $signed(audio), 0);
         check("rst_valid", audio_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_full", cmd_full, 1);
         check("rst_err", cmd_err, 0);
      end
      // Release reset with cmd_wren still high: cmd_full is still 1 on that edge, so the command is dropped.
      rst         = 1'b0;
      sample_tick = 1'b0;
      step();
      cmd_wren = 1'b0;
      check("rst_full_drop", cmd_full, 0);
      check("rst_cmd_dropped", busy, 0);
      check("rst_no_valid", audio_valid, 0);

      // 2. Attack to sustain, voice 0, period 5, ticks 100 clocks apart, all on a pol=1 phase.
      send(32'h0000_0005, 1'b0);
      check("on_busy", busy, 4'b0001);
      idle(5);
      for (int j = 1; j <= 18; j++) begin
         if (j > 1) idle(99);
         tick();
         lvl = (j == 1) ? 0 : ((16 * (j - 1) > 255) ? 255 : 16 * (j - 1));
         check("attack_audio", $signed(audio), lvl * 8192);
         check("attack_valid", audio_valid, 1);
      end
      // Back-to-back ticks in sustain show the 5-clock polarity pattern at full level.
      for (int i = 0; i < 10; i++) begin
         tick();
         check("sustain_pol", $signed(audio), sgn_sustain[i] * 2088960);
      end

      // 3. Release: note off, then ticks 100 clocks apart, again sampling pol=1.
      send(32'h0000_0000, 1'b0);
      check("off_valid_drop", audio_valid, 0);
      check("off_busy", busy, 4'b0001);
      idle(88);
      for (int r = 1; r <= 32; r++) begin
         if (r > 1) idle(99);
         tick();
         check("release_audio", $signed(audio), (255 - 8 * (r - 1)) * 8192);
         check("release_busy", busy, (r < 32) ? 1 : 0);
      end
      tick();
      check("idle_audio", $signed(audio), 0);

      // 4. Full mix: reset, then four voices at period 1 written every other cycle so they are in phase.
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("rst2_full", cmd_full, 0);
      send(32'h0000_0001, 1'b0);
      step();
      send(32'h1000_0001, 1'b0);
      step();
      send(32'h2000_0001, 1'b0);
      step();
      send(32'h3000_0001, 1'b0);
      check("mix_busy", busy, 4'b1111);
      repeat (16) tick();
      tick();
      check("mix_neg", $signed(audio), -8355840);
      tick();
      check("mix_pos", $signed(audio), 8355840);
      tick();
      check("mix_neg2", $signed(audio), -8355840);
      tick();
      check("mix_pos2", $signed(audio), 8355840);

      // 5. Bad voice index.
      send(32'h5000_0010, 1'b0);
      check("bad_err", cmd_err, 1);
      check("bad_busy", busy, 4'b1111);
      check("bad_audio", $signed(audio), 8355840);
      check("bad_valid", audio_valid, 0);
      step();
      check("bad_err_pulse", cmd_err, 0);
      check("bad_busy2", busy, 4'b1111);

      // 6a. Note off for voice 1 with a coincident tick: sample uses pre-command values, step skipped.
      send(32'h1000_0000, 1'b1);
      check("coll_audio", $signed(audio), -8355840);
      check("coll_valid", audio_valid, 1);
      check("coll_busy", busy, 4'b1111);
      tick();
      check("coll_skip", $signed(audio), 8355840);
      tick();
      check("coll_release", $signed(audio), -8290304);

      // 6b. Reset in the middle of an attack, with a command and a tick in the same cycle.
      send(32'h2000_0001, 1'b0);
      rst         = 1'b1;
      cmd_wren    = 1'b1;
      cmd_data    = 32'h3000_0001;
      sample_tick = 1'b1;
      step();
      rst         = 1'b0;
      cmd_wren    = 1'b0;
      sample_tick = 1'b0;
      check("mid_rst_audio", $signed(audio), 0);
      check("mid_rst_valid", audio_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_full", cmd_full, 1);
      check("mid_rst_err", cmd_err, 0);
      step();
      check("mid_rst_full_drop", cmd_full, 0);
      tick();
      check("mid_rst_level0", $signed(audio), 0);
      check("mid_rst_tick_valid", audio_valid, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
